bit_reverse_reorder: RTL and testbench
======================================

BIT_REVERSE_REORDER -- requirements
Module: bit_reverse_reorder

Interface
REQ-001 SHALL have parameter SAMPLES, default 4, meaning frame length in samples; power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default 3, meaning bits per sample.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, WIDTH bits: natural-order sample.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 SHALL have port out_data, output, WIDTH bits: reordered sample.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-011 SHALL have port out_last, output, 1 bit: out_data is the final sample of a frame.

Function
REQ-012 SHALL hold two banks of SAMPLES x WIDTH storage, used ping-pong: one bank fills while the other drains.
REQ-013 SHALL treat a transfer as occurring only when valid and ready are both high at a rising edge, on either side.
REQ-014 SHALL write the k-th accepted sample of a frame to index k of the current write bank (wr_idx 0..SAMPLES-1).
REQ-015 SHALL, on acceptance at wr_idx = SAMPLES-1, mark the write bank FULL, wrap wr_idx to 0 and toggle the write bank.
REQ-016 SHALL drive in_ready = 1 exactly when the current write bank is not FULL; in_ready is a function of registered state only.
REQ-017 SHALL drive out_valid = 1 exactly when the current read bank is FULL.
REQ-018 SHALL drive out_data = readbank[bitrev(rd_idx)], where bitrev mirrors the log2(SAMPLES) index bits.
REQ-019 SHALL drive out_last = out_valid AND (rd_idx = SAMPLES-1).
REQ-020 SHALL, on an output transfer with out_last high, clear FULL on the read bank, wrap rd_idx to 0 and toggle the read bank.
REQ-021 SHALL assert out_valid for the first sample of a frame in the cycle immediately after that frame's last input transfer.
REQ-022 SHALL sustain one sample per cycle in and out indefinitely when in_valid and out_ready are held high.
REQ-023 SHALL make a bank freed in cycle N writable no earlier than cycle N+1; a simultaneous final read and write-bank-full condition SHALL NOT let a sample overwrite undrained data.
REQ-024 SHALL hold out_data and out_last stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL ignore in_data whenever in_valid = 0, and SHALL ignore out_ready whenever out_valid = 0.

Reset
REQ-026 SHALL, on rst = 1 at a clock edge, clear both FULL flags, set wr_idx = rd_idx = 0 and set both bank selects to bank 0.
REQ-027 SHALL output out_valid = 0, out_last = 0 and in_ready = 1 in the first cycle after reset.
REQ-028 SHALL discard any partial or undrained frame on reset mid-operation; storage contents need not be cleared.

Configuration
REQ-029 SHALL add input port natural_mode (1 bit) when macro BIT_REVERSE_NATURAL_MODE_EN is defined.
REQ-030 SHALL, with the macro defined, latch natural_mode per bank at that bank's first input transfer.
REQ-031 SHALL, for a bank whose latched natural_mode = 1, drain it with out_data = readbank[rd_idx] (no reordering).
REQ-032 SHALL, without the macro, have no natural_mode port and always drain in bit-reversed order.

Structure
REQ-033 SHALL place the bitrev index function, the per-bank state typedef (EMPTY/FULL) and the log2(SAMPLES) index-width helper in shared package fft_pkg.
REQ-034 SHALL implement a single bank as sub-module reorder_bank (write port with index, combinational read port with index), instantiated twice.

Verification (SAMPLES=4, WIDTH=3 unless stated)
REQ-035 SHALL cover: in 110,010,000,111 with out_ready=1 -> out 110,000,010,111, out_last on the 4th sample, first out_valid one cycle after the 4th input.
REQ-036 SHALL cover: three back-to-back frames with in_valid=out_ready=1 -> no in_ready deassertion after the first frame; each frame's output in order 0,2,1,3.
REQ-037 SHALL cover: out_ready=0 throughout while 8 samples are sent -> in_ready drops after the 8th accepted sample; out_data is held stable.
REQ-038 SHALL cover: rst asserted after 2 inputs of a frame -> next cycle out_valid=0, in_ready=1; a following full frame is output correctly.
REQ-039 SHALL cover: SAMPLES=8, inputs 0..7 -> out 0,4,2,6,1,5,3,7.
REQ-040 SHALL cover, with BIT_REVERSE_NATURAL_MODE_EN defined: frame A with natural_mode=1 and frame B with natural_mode=0 -> A drained as 0,1,2,3 and B as 0,2,1,3.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the bit-reversal reorder buffer:
// per-bank fill state, index-width helper and index bit mirroring.
package fft_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  function automatic int idx_width(input int samples);
    return (samples <= 2) ? 1 : $clog2(samples);
  endfunction

  // Mirror the low nbits of idx (bit 0 becomes bit nbits-1).
  function automatic int bitrev(input int idx, input int nbits);
    int r;
    r = 0;
    for (int i = 0; i < nbits; i++) begin
      r = (r << 1) | ((idx >> i) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One SAMPLES x WIDTH frame buffer: synchronous indexed write,
// combinational indexed read.
module reorder_bank
  import fft_pkg::*;
#(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 3
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [idx_width(SAMPLES)-1:0] wr_idx,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [idx_width(SAMPLES)-1:0] rd_idx,
  output logic [WIDTH-1:0]              rd_data
);

  logic [WIDTH-1:0] mem_reg [SAMPLES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/bit_reverse_reorder.sv
// Ping-pong frame buffer that drains each frame in bit-reversed index order.
// Optional BIT_REVERSE_NATURAL_MODE_EN adds a per-frame natural-order drain.
module bit_reverse_reorder
  import fft_pkg::*;
#(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 3
) (
  input  logic             clk,
  input  logic             rst,
`ifdef BIT_REVERSE_NATURAL_MODE_EN
  input  logic             natural_mode,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int IW = idx_width(SAMPLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES - 1);

  logic [IW-1:0]    wr_idx_reg;
  logic [IW-1:0]    rd_idx_reg;
  logic             wr_bank_reg;
  logic             rd_bank_reg;
  logic [1:0]       full_vec;
  logic [1:0]       nat_vec;
  logic [IW-1:0]    rev_idx;
  logic [IW-1:0]    rd_addr;
  logic [WIDTH-1:0] bank_rd_data [2];
  logic             in_xfer;
  logic             out_xfer;

  // Handshake outputs depend only on registered bank state.
  assign in_ready  = !full_vec[wr_bank_reg];
  assign out_valid = full_vec[rd_bank_reg];
  assign out_last  = out_valid && (rd_idx_reg == LAST_IDX);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign rev_idx  = IW'(bitrev(int'(rd_idx_reg), IW));
  assign rd_addr  = nat_vec[rd_bank_reg] ? rd_idx_reg : rev_idx;
  assign out_data = bank_rd_data[rd_bank_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_reg  <= '0;
      rd_idx_reg  <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
    end else begin
      if (in_xfer) begin
        wr_idx_reg <= (wr_idx_reg == LAST_IDX) ? '0 : wr_idx_reg + IW'(1);
        if (wr_idx_reg == LAST_IDX) begin
          wr_bank_reg <= !wr_bank_reg;
        end
      end
      if (out_xfer) begin
        rd_idx_reg <= out_last ? '0 : rd_idx_reg + IW'(1);
        if (out_last) begin
          rd_bank_reg <= !rd_bank_reg;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic BANK_ID = 1'(gi);

      bank_state_t state_reg;
      logic        nat_reg;
      logic        wr_here;

      assign wr_here      = in_xfer && (wr_bank_reg == BANK_ID);
      assign full_vec[gi] = (state_reg == FULL);

      // A bank is only written while EMPTY and only drained while FULL,
      // so fill and drain never target the same bank on one edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= EMPTY;
        end else if (wr_here && (wr_idx_reg == LAST_IDX)) begin
          state_reg <= FULL;
        end else if (out_xfer && out_last && (rd_bank_reg == BANK_ID)) begin
          state_reg <= EMPTY;
        end
      end

`ifdef BIT_REVERSE_NATURAL_MODE_EN
      always_ff @(posedge clk) begin
        if (rst) begin
          nat_reg <= 1'b0;
        end else if (wr_here && (wr_idx_reg == '0)) begin
          nat_reg <= natural_mode;
        end
      end
`else
      assign nat_reg = 1'b0;
`endif
      assign nat_vec[gi] = nat_reg;

      reorder_bank #(
        .SAMPLES(SAMPLES),
        .WIDTH  (WIDTH)
      ) u_bank (
        .clk    (clk),
        .wr_en  (wr_here),
        .wr_idx (wr_idx_reg),
        .wr_data(in_data),
        .rd_idx (rd_addr),
        .rd_data(bank_rd_data[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Randomized and directed bench for bit_reverse_reorder against a frame-level
// reference model (complete frames reordered with arithmetic bit reversal).
module tb_bit_reverse_reorder;

  localparam int S  = 4;
  localparam int W  = 3;
  localparam int S8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [W-1:0] in_data, out_data;
  logic         rst8, in_valid8, in_ready8, out_valid8, out_ready8, out_last8;
  logic [W-1:0] in_data8, out_data8;
`ifdef BIT_REVERSE_NATURAL_MODE_EN
  logic natural_mode;
  logic natural_mode8;
`endif

  bit_reverse_reorder #(.SAMPLES(S), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef BIT_REVERSE_NATURAL_MODE_EN
    .natural_mode(natural_mode),
`endif
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  bit_reverse_reorder #(.SAMPLES(S8), .WIDTH(W)) dut8 (
    .clk      (clk),
    .rst      (rst8),
`ifdef BIT_REVERSE_NATURAL_MODE_EN
    .natural_mode(natural_mode8),
`endif
    .in_data  (in_data8),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .out_data (out_data8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .out_last (out_last8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model state: frames in flight, not RTL state.
  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] cur_frame[$];
  logic [W-1:0] obs_q[$];
  int           full_cnt;
  bit           cur_nat;
  bit           hold_pending;
  logic [W-1:0] hold_data;
  logic         hold_last;
  bit           last_ix;

  function automatic int rev_index(input int k, input int n);
    int r = 0;
    int m = n;
    int v = k;
    while (m > 1) begin
      r = r * 2 + v % 2;
      v = v / 2;
      m = m / 2;
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cur_frame.delete();
    full_cnt     = 0;
    hold_pending = 0;
  endtask

  // One clock: check at negedge, advance model at posedge, inputs change at +1.
  task automatic cycle();
    bit           ix, ox, frame_out;
    bit           nat_now;
    logic [W-1:0] din;
    exp_t         e;
    frame_out = 0;
    nat_now   = 0;
    @(negedge clk);
    if (!rst) begin
      check("in_ready", in_ready, (full_cnt < 2));
      check("out_valid", out_valid, (full_cnt > 0));
      if (full_cnt == 0) check("out_last_idle", out_last, 0);
      if (hold_pending) begin
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
    end
    ix  = !rst && in_valid && in_ready;
    ox  = !rst && out_valid && out_ready;
    din = in_data;
`ifdef BIT_REVERSE_NATURAL_MODE_EN
    nat_now = natural_mode;
`endif
    hold_pending = !rst && out_valid && !out_ready;
    hold_data    = out_data;
    hold_last    = out_last;
    if (ox) begin
      $display("out data=%0d last=%0b", out_data, out_last);
      obs_q.push_back(out_data);
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
        frame_out = e.last;
      end
    end
    @(posedge clk);
    last_ix = ix;
    if (rst) begin
      model_reset();
    end else begin
      if (ix) begin
        $display("in  data=%0d", din);
        if (cur_frame.size() == 0) cur_nat = nat_now;
        cur_frame.push_back(din);
        if (cur_frame.size() == S) begin
          for (int k = 0; k < S; k++) begin
            e.data = cur_frame[cur_nat ? k : rev_index(k, S)];
            e.last = (k == S - 1);
            exp_q.push_back(e);
          end
          cur_frame.delete();
          full_cnt++;
        end
      end
      if (frame_out) full_cnt--;
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 0;
    out_ready = 1;
    while (exp_q.size() > 0 && n < 100) begin
      cycle();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic send(input logic [W-1:0] v);
    in_valid = 1;
    in_data  = v;
    cycle();
  endtask

  int exp35 [4] = '{6, 0, 2, 7};
  int exp39 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`ifdef BIT_REVERSE_NATURAL_MODE_EN
  int exp40 [8] = '{0, 1, 2, 3, 0, 2, 1, 3};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int acc;
    rst = 1; in_valid = 0; in_data = '0; out_ready = 0;
    rst8 = 1; in_valid8 = 0; in_data8 = '0; out_ready8 = 0;
`ifdef BIT_REVERSE_NATURAL_MODE_EN
    natural_mode = 0;
    natural_mode8 = 0;
`endif
    model_reset();
    cycle();
    cycle();
    rst = 0;

    // Directed frame: 110,010,000,111 -> 110,000,010,111
    out_ready = 1;
    obs_q.delete();
    send(3'b110); send(3'b010); send(3'b000); send(3'b111);
    drain();
    check("t35_count", obs_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t35_order", obs_q[i], exp35[i]);

    // Three back-to-back frames at full rate
    stalls = 0;
    out_ready = 1;
    for (int i = 0; i < 3 * S; i++) begin
      if (i >= S && !in_ready) stalls++;
      send(W'($urandom));
    end
    check("b2b_stalls", stalls, 0);
    drain();

    // Downstream blocked: two frames fill, then input stalls
    out_ready = 0;
    acc = 0;
    for (int i = 0; i < 20 && acc < 2 * S; i++) begin
      send(W'($urandom));
      if (last_ix) acc++;
    end
    check("blocked_accepted", acc, 2 * S);
    check("blocked_in_ready", in_ready, 0);
    in_valid = 0;
    for (int i = 0; i < 3; i++) cycle();
    drain();

    // Reset mid-frame discards the partial frame
    out_ready = 1;
    send(W'(1)); send(W'(2));
    in_valid = 0;
    rst = 1;
    cycle();
    rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    obs_q.delete();
    for (int i = 0; i < S; i++) send(W'(4 + i));
    drain();
    check("rst_frame_count", obs_q.size(), S);

`ifdef BIT_REVERSE_NATURAL_MODE_EN
    // Frame A natural (mode dropped after first sample), frame B reversed
    obs_q.delete();
    out_ready = 0;
    natural_mode = 1;
    send(W'(0));
    natural_mode = 0;
    for (int i = 1; i < S; i++) send(W'(i));
    for (int i = 0; i < S; i++) send(W'(i));
    drain();
    check("t40_count", obs_q.size(), 8);
    for (int i = 0; i < 8; i++) check("t40_order", obs_q[i], exp40[i]);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = W'($urandom);
`ifdef BIT_REVERSE_NATURAL_MODE_EN
      natural_mode = $urandom % 2;
`endif
      cycle();
    end
    while (cur_frame.size() != 0) send(W'($urandom));
    drain();

    // SAMPLES=8 instance: inputs 0..7
    @(posedge clk); #1;
    rst8 = 0;
    for (int i = 0; i < S8; i++) begin
      in_valid8 = 1;
      in_data8  = W'(i);
      @(negedge clk);
      check("s8_in_ready", in_ready8, 1);
      $display("in8 data=%0d", i);
      @(posedge clk); #1;
    end
    in_valid8  = 0;
    out_ready8 = 1;
    begin
      int got = 0;
      for (int n = 0; n < 30 && got < S8; n++) begin
        @(negedge clk);
        if (n == 0) check("s8_first_valid", out_valid8, 1);
        if (out_valid8) begin
          $display("out8 data=%0d last=%0b", out_data8, out_last8);
          check("s8_order", out_data8, exp39[got]);
          check("s8_last", out_last8, (got == S8 - 1));
          got++;
        end
        @(posedge clk); #1;
      end
      check("s8_count", got, S8);
    end
    @(negedge clk);
    check("s8_idle", out_valid8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
